hist_bin_dispatcher: RTL and testbench

- Parametrised successor to the fixed 2-bit/6-bit plot distributor in the time-correlation analyser.
- Converts each start/end/interval record from the time-tagger into a histogram bin address around a configurable centre bin.
- Queues converted records in a small FIFO and issues them to the histogram RAM incrementer over a req/ack handshake.
- Counts dropped, out-of-range and overflowed events for host readout.

---
 rtl/hist_bin_dispatcher.sv | 171 +++++++++++++++++
 tb/tb_hist_bin_dispatcher.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_bin_dispatcher.sv
// hist_bin_dispatcher: time-tagger record to histogram bin converter,
// with a small pending FIFO and a req/ack dispatcher to the incrementer.
module hist_bin_dispatcher #(
    parameter int CH_W       = 2,
    parameter int INT_W      = 6,
    parameter int ADDR_W     = 7,
    parameter int CENTER     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [CH_W-1:0]               cfg_ch_a,
    input  logic [CH_W-1:0]               cfg_ch_b,
    input  logic [CH_W-1:0]               start_ch,
    input  logic [CH_W-1:0]               end_ch,
    input  logic [INT_W-1:0]              interval,
    input  logic                          data_arrived,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_req,
    input  logic                          mem_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [CNT_W-1:0]              oor_cnt,
    output logic [CNT_W-1:0]              ovf_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = ADDR_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    logic [2:0]               sync_q;
    logic                     ev;
    logic                     is_ab;
    logic                     is_ba;
    logic                     match;
    logic signed [BW-1:0]     center_s;
    logic signed [BW-1:0]     ival_s;
    logic signed [BW-1:0]     bin;
    logic                     oor;
    logic                     accept;
    logic                     valid_ev;
    logic                     drop_inc;
    logic                     oor_inc;
    logic                     ovf_inc;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [PW:0]              count;
    logic [ADDR_W-1:0]        fifo_mem [FIFO_DEPTH];
    state_t                   state_q;
    state_t                   state_d;

    // Synchronise the asynchronous record-valid level into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], data_arrived};
    end

    assign ev     = (sync_q[2:1] == 2'b01);
    assign accept = ev & enable;

    assign is_ab = (start_ch == cfg_ch_a) && (end_ch == cfg_ch_b);
    assign is_ba = !is_ab && (start_ch == cfg_ch_b) && (end_ch == cfg_ch_a);
    assign match = is_ab | is_ba;

    assign center_s = BW'(CENTER);
    assign ival_s   = BW'(interval);

    // Signed bin offset from the centre; direction follows the channel order
    always_comb begin
        bin = center_s;
        if (is_ab) bin = center_s + ival_s;
        else       bin = center_s - ival_s;
    end

    // Any set bit above the address range (incl. sign) means out of range
    assign oor = |bin[BW-1:ADDR_W];

    assign valid_ev = accept & match & ~oor;
    assign drop_inc = accept & ~match;
    assign oor_inc  = accept & match & oor;

    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);

    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign push    = valid_ev & (~full | pop);
    assign ovf_inc = valid_ev & full & ~pop;

    // FIFO pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bin[ADDR_W-1:0];
    end

    assign fifo_level = count;

    // Dispatcher state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Dispatcher next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!empty) state_d = S_REQ;
            S_REQ:   if (mem_ack) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Dispatcher outputs: pop on leaving IDLE, request while in REQ
    always_comb begin
        pop     = 1'b0;
        mem_req = 1'b0;
        unique case (state_q)
            S_IDLE:  pop = !empty;
            S_REQ:   mem_req = 1'b1;
            default: ;
        endcase
    end

    // Latch the FIFO head as the request address when it is popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   mem_addr <= '0;
        else if (pop) mem_addr <= fifo_mem[rd_ptr];
    end

    // Saturating diagnostic counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            oor_cnt  <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            if (oor_inc  && oor_cnt  != '1) oor_cnt  <= oor_cnt + 1'b1;
            if (ovf_inc  && ovf_cnt  != '1) ovf_cnt  <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hist_bin_dispatcher.sv
// tb_hist_bin_dispatcher: directed self-checking bench.
// Three instances: default, CENTER=10, CNT_W=4.
module tb_hist_bin_dispatcher;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [1:0] cfg_ch_a;
    logic [1:0] cfg_ch_b;
    logic [1:0] start_ch;
    logic [1:0] end_ch;
    logic [5:0] interval;
    logic       data_arrived;
    logic       mem_ack;

    logic [6:0]  mem_addr;
    logic        mem_req;
    logic [2:0]  fifo_level;
    logic [15:0] drop_cnt;
    logic [15:0] oor_cnt;
    logic [15:0] ovf_cnt;

    logic [6:0]  c10_addr;
    logic        c10_req;
    logic [2:0]  c10_level;
    logic [15:0] c10_drop;
    logic [15:0] c10_oor;
    logic [15:0] c10_ovf;

    logic [6:0]  c4_addr;
    logic        c4_req;
    logic [2:0]  c4_level;
    logic [3:0]  c4_drop;
    logic [3:0]  c4_oor;
    logic [3:0]  c4_ovf;

    int n_cmp;
    int n_bad;

    hist_bin_dispatcher u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_ch_a(cfg_ch_a), .cfg_ch_b(cfg_ch_b),
        .start_ch(start_ch), .end_ch(end_ch), .interval(interval),
        .data_arrived(data_arrived),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt),
        .oor_cnt(oor_cnt), .ovf_cnt(ovf_cnt)
    );

    hist_bin_dispatcher #(.CENTER(10)) u_c10 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_ch_a(cfg_ch_a), .cfg_ch_b(cfg_ch_b),
        .start_ch(start_ch), .end_ch(end_ch), .interval(interval),
        .data_arrived(data_arrived),
        .mem_addr(c10_addr), .mem_req(c10_req), .mem_ack(mem_ack),
        .fifo_level(c10_level), .drop_cnt(c10_drop),
        .oor_cnt(c10_oor), .ovf_cnt(c10_ovf)
    );

    hist_bin_dispatcher #(.CNT_W(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_ch_a(cfg_ch_a), .cfg_ch_b(cfg_ch_b),
        .start_ch(start_ch), .end_ch(end_ch), .interval(interval),
        .data_arrived(data_arrived),
        .mem_addr(c4_addr), .mem_req(c4_req), .mem_ack(mem_ack),
        .fifo_level(c4_level), .drop_cnt(c4_drop),
        .oor_cnt(c4_oor), .ovf_cnt(c4_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n        = 1'b0;
        enable       = 1'b1;
        cfg_ch_a     = 2'd1;
        cfg_ch_b     = 2'd2;
        start_ch     = 2'd0;
        end_ch       = 2'd0;
        interval     = 6'd0;
        data_arrived = 1'b0;
        mem_ack      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Present one record and let it fully pass the edge detector
    task automatic send(input logic [1:0] s, input logic [1:0] e,
                        input logic [5:0] iv);
        @(negedge clk);
        start_ch     = s;
        end_ch       = e;
        interval     = iv;
        data_arrived = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        data_arrived = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Wait (bounded) for a request on the default instance and ack it
    task automatic get_req(output logic [6:0] a, output bit ok,
                           output logic req_after);
        ok        = 1'b0;
        a         = '0;
        req_after = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                ok = 1'b1;
                a  = mem_addr;
            end
        end
        if (ok) begin
            @(negedge clk);
            mem_ack = 1'b1;
            @(posedge clk);
            #1;
            req_after = mem_req;
            @(negedge clk);
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        data_arrived = 1'b0;
        mem_ack = 1'b0;
        #3;
        n_cmp++;
        if ({mem_req, mem_addr, fifo_level} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got req=%0b addr=%0d lvl=%0d want 0",
                     mem_req, mem_addr, fifo_level);
        end
        n_cmp++;
        if ({drop_cnt, oor_cnt, ovf_cnt} !== 48'd0) begin
            n_bad++;
            $display("FAIL reset_cnts: got %0d/%0d/%0d want 0/0/0",
                     drop_cnt, oor_cnt, ovf_cnt);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        @(negedge clk);
        start_ch     = 2'd1;
        end_ch       = 2'd2;
        interval     = 6'd5;
        data_arrived = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || fifo_level !== 3'd1) begin
            n_bad++;
            $display("FAIL basic_e1: got req=%0b lvl=%0d want req=0 lvl=1",
                     mem_req, fifo_level);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 7'd69) begin
            n_bad++;
            $display("FAIL basic_e2: got req=%0b addr=%0d want req=1 addr=69",
                     mem_req, mem_addr);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 7'd69) begin
            n_bad++;
            $display("FAIL basic_hold: got req=%0b addr=%0d want req=1 addr=69",
                     mem_req, mem_addr);
        end
        @(negedge clk);
        mem_ack      = 1'b1;
        data_arrived = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_ack_drop: got req=%0b want 0", mem_req);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || fifo_level !== 3'd0) begin
            n_bad++;
            $display("FAIL basic_gap: got req=%0b lvl=%0d want 0/0",
                     mem_req, fifo_level);
        end
    endtask

    task automatic test_reverse();
        logic [6:0] a;
        bit         ok;
        logic       ra;
        do_reset();
        send(2'd2, 2'd1, 6'd63);
        get_req(a, ok, ra);
        n_cmp++;
        if (!ok || a !== 7'd1) begin
            n_bad++;
            $display("FAIL rev_63: got ok=%0b addr=%0d want addr=1", ok, a);
        end
        send(2'd2, 2'd1, 6'd0);
        get_req(a, ok, ra);
        n_cmp++;
        if (!ok || a !== 7'd64) begin
            n_bad++;
            $display("FAIL rev_0: got ok=%0b addr=%0d want addr=64", ok, a);
        end
        send(2'd1, 2'd2, 6'd63);
        get_req(a, ok, ra);
        n_cmp++;
        if (!ok || a !== 7'd127) begin
            n_bad++;
            $display("FAIL fwd_top: got ok=%0b addr=%0d want addr=127", ok, a);
        end
        cfg_ch_b = 2'd1;
        send(2'd1, 2'd1, 6'd3);
        get_req(a, ok, ra);
        n_cmp++;
        if (!ok || a !== 7'd67) begin
            n_bad++;
            $display("FAIL same_ab: got ok=%0b addr=%0d want addr=67", ok, a);
        end
        cfg_ch_b = 2'd2;
    endtask

    task automatic test_oor();
        logic [6:0] a;
        bit         ok;
        logic       ra;
        logic       seen;
        do_reset();
        send(2'd2, 2'd1, 6'd11);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (c10_req) seen = 1'b1;
        end
        n_cmp++;
        if (c10_oor !== 16'd1 || seen !== 1'b0 || c10_level !== 3'd0) begin
            n_bad++;
            $display("FAIL oor_c10: got oor=%0d req=%0b lvl=%0d want 1/0/0",
                     c10_oor, seen, c10_level);
        end
        get_req(a, ok, ra);
        n_cmp++;
        if (!ok || a !== 7'd53 || oor_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL oor_main: got ok=%0b addr=%0d oor=%0d want 53/0",
                     ok, a, oor_cnt);
        end
    endtask

    task automatic test_drop();
        logic seen;
        do_reset();
        send(2'd0, 2'd3, 6'd0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (mem_req) seen = 1'b1;
        end
        n_cmp++;
        if (drop_cnt !== 16'd1 || seen !== 1'b0 || fifo_level !== 3'd0) begin
            n_bad++;
            $display("FAIL drop: got drop=%0d req=%0b lvl=%0d want 1/0/0",
                     drop_cnt, seen, fifo_level);
        end
        enable = 1'b0;
        send(2'd0, 2'd3, 6'd0);
        send(2'd1, 2'd2, 6'd4);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (mem_req) seen = 1'b1;
        end
        n_cmp++;
        if (drop_cnt !== 16'd1 || seen !== 1'b0 || fifo_level !== 3'd0) begin
            n_bad++;
            $display("FAIL disabled: got drop=%0d req=%0b lvl=%0d want 1/0/0",
                     drop_cnt, seen, fifo_level);
        end
        enable = 1'b1;
    endtask

    task automatic test_overflow();
        logic [6:0] a;
        bit         ok;
        logic       ra;
        do_reset();
        for (int k = 1; k <= 6; k++) send(2'd1, 2'd2, 6'(k));
        #1;
        n_cmp++;
        if (fifo_level !== 3'd4 || ovf_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL ovf_fill: got lvl=%0d ovf=%0d want 4/1",
                     fifo_level, ovf_cnt);
        end
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 7'd65) begin
            n_bad++;
            $display("FAIL ovf_inflight: got req=%0b addr=%0d want 1/65",
                     mem_req, mem_addr);
        end
        for (int k = 0; k < 5; k++) begin
            get_req(a, ok, ra);
            n_cmp++;
            if (!ok || a !== 7'(65 + k) || ra !== 1'b0) begin
                n_bad++;
                $display("FAIL drain_%0d: got ok=%0b addr=%0d req_after=%0b want %0d/0",
                         k, ok, a, ra, 65 + k);
            end
        end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || fifo_level !== 3'd0) begin
            n_bad++;
            $display("FAIL drain_end: got req=%0b lvl=%0d want 0/0",
                     mem_req, fifo_level);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] a;
        bit         ok;
        logic       ra;
        do_reset();
        send(2'd0, 2'd0, 6'd0);
        for (int k = 1; k <= 4; k++) send(2'd1, 2'd2, 6'(k));
        #1;
        n_cmp++;
        if (mem_req !== 1'b1 || fifo_level !== 3'd3 || drop_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL mid_pre: got req=%0b lvl=%0d drop=%0d want 1/3/1",
                     mem_req, fifo_level, drop_cnt);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || fifo_level !== 3'd0 || mem_addr !== 7'd0 ||
            drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_async: got req=%0b lvl=%0d addr=%0d drop=%0d want 0",
                     mem_req, fifo_level, mem_addr, drop_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(2'd1, 2'd2, 6'd7);
        get_req(a, ok, ra);
        n_cmp++;
        if (!ok || a !== 7'd71) begin
            n_bad++;
            $display("FAIL mid_after: got ok=%0b addr=%0d want 71", ok, a);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 20; k++) send(2'd0, 2'd3, 6'd0);
        #1;
        n_cmp++;
        if (c4_drop !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_c4: got drop=%0d want 15", c4_drop);
        end
        n_cmp++;
        if (drop_cnt !== 16'd20) begin
            n_bad++;
            $display("FAIL sat_main: got drop=%0d want 20", drop_cnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        enable = 1'b1;
        cfg_ch_a = 2'd1;
        cfg_ch_b = 2'd2;
        start_ch = 2'd0;
        end_ch = 2'd0;
        interval = 6'd0;
        data_arrived = 1'b0;
        mem_ack = 1'b0;
        test_reset();
        test_basic();
        test_reverse();
        test_oor();
        test_drop();
        test_overflow();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
